alu_iter: RTL

- Parametrised, multi-cycle RISC-V integer ALU with valid/ready handshakes on both input and output.
- Single-cycle logic/arithmetic ops complete in one cycle.
- Shifts run iteratively, SHIFT_STEP bits per cycle. MUL runs as an iterative shift-add.
- Sits between decode/operand-fetch and writeback; the core stalls on in_ready/out_valid.

---
 rtl/alu_iter_if.sv | 25 ++
 rtl/alu_iter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/alu_iter_if.sv
// rtl/alu_iter_if.sv - request/result handshake bundle for the iterative ALU
interface alu_iter_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       alu_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             illegal_op;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, alu_sel, out_ready,
        input  in_ready, out_valid, result, illegal_op, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, alu_sel, out_ready,
        output in_ready, out_valid, result, illegal_op, busy
    );
endinterface

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - multi-cycle integer ALU: iterative shifts and shift-add multiply
module alu_iter #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1,
    parameter int MUL_EN     = 1
) (
    input logic       clk,
    input logic       rst_n,
    alu_iter_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    logic             illegal_q;

    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] quick;
    logic             is_shift;
    logic             is_mul;
    logic             is_illegal;
    logic [CW-1:0]    step;

    assign shamt      = bus.op_b[SW-1:0];
    assign is_shift   = (bus.alu_sel == OP_SLL) || (bus.alu_sel == OP_SRL) || (bus.alu_sel == OP_SRA);
    assign is_mul     = (bus.alu_sel == OP_MUL) && (MUL_EN != 0);
    assign is_illegal = (bus.alu_sel > OP_MUL) || ((bus.alu_sel == OP_MUL) && (MUL_EN == 0));
    assign step       = (cnt > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : cnt;

    // Shifts land here only with shamt=0, where the result is op_a unchanged.
    always_comb begin
        quick = '0;
        case (bus.alu_sel)
            OP_ADD:  quick = bus.op_a + bus.op_b;
            OP_SUB:  quick = bus.op_a - bus.op_b;
            OP_XOR:  quick = bus.op_a ^ bus.op_b;
            OP_OR:   quick = bus.op_a | bus.op_b;
            OP_AND:  quick = bus.op_a & bus.op_b;
            OP_SLT:  quick = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            OP_SLTU: quick = {{(WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
            OP_SLL, OP_SRL, OP_SRA: quick = bus.op_a;
            default: quick = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q      <= bus.alu_sel;
                        illegal_q <= is_illegal;
                        if (is_mul) begin
                            acc    <= '0;
                            mcand  <= bus.op_a;
                            mplier <= bus.op_b;
                            cnt    <= CW'(WIDTH);
                            state  <= EXEC;
                        end else if (is_shift && (shamt != '0)) begin
                            acc   <= bus.op_a;
                            cnt   <= {1'b0, shamt};
                            state <= EXEC;
                        end else begin
                            acc   <= quick;
                            state <= DONE;
                        end
                    end
                end
                EXEC: begin
                    if (op_q == OP_MUL) begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= DONE;
                    end else begin
                        case (op_q)
                            OP_SLL:  acc <= acc << step;
                            OP_SRL:  acc <= acc >> step;
                            default: acc <= $unsigned($signed(acc) >>> step);
                        endcase
                        cnt <= cnt - step;
                        if (cnt == step) state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.busy       = (state != IDLE);
    assign bus.result     = acc;
    assign bus.illegal_op = illegal_q;
endmodule
